// File: rtl/mem_interface.sv
// mem_interface: memory access unit between the multi-cycle controller and a
// unified instruction/data memory port. Converts controller strobes into
// request/ready transactions, holds IR and MDR, decodes IR fields and stalls
// the controller while an access is outstanding.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no access outstanding; a command is accepted this cycle
//   BUSY  | mem_req high, waiting for mem_ready or the timeout abort
module mem_interface #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic [31:0] PC,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WriteData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        Stall,
    output logic [31:0] Instruction,
    output logic [5:0]  OpCode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic [25:0] JumpAddr,
    output logic [31:0] MDR,
    output logic        AlignErr,
    output logic        CmdErr,
    output logic        TimeoutErr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Count value on the last BUSY cycle before an unanswered access aborts.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_ir_load;
    logic [7:0]  r_cnt;
    logic [31:0] r_ir;
    logic [31:0] r_mdr;
    logic        r_align_err;
    logic        r_cmd_err;
    logic        r_timeout_err;

    logic        w_cmd;
    logic        w_accept;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_sel_addr;

    // Next-state decode, handshake qualifiers and the combinational stall.
    always_comb begin
        w_next_state = r_state;
        w_cmd        = MemRead | MemWrite;
        w_sel_addr   = IorD ? ALUOut : PC;
        w_accept     = (r_state == ST_IDLE) && w_cmd;
        w_done       = (r_state == ST_BUSY) && mem_ready;
        w_timeout    = (r_state == ST_BUSY) && !mem_ready && (r_cnt == TO_LAST);
        // The stall drops in the completing or aborting cycle so the
        // controller advances on the same edge that ends the access.
        Stall        = w_accept || ((r_state == ST_BUSY) && !mem_ready && !w_timeout);
        case (r_state)
            ST_IDLE: if (w_cmd) w_next_state = ST_BUSY;
            ST_BUSY: if (w_done || w_timeout) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Latch the request on acceptance; held constant through BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_ir_load <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= {w_sel_addr[31:2], 2'b00};
            r_we      <= MemWrite;
            r_wdata   <= WriteData;
            r_ir_load <= IRWrite & ~MemWrite;
        end
    end

    // Wait-cycle counter: cleared on entry to BUSY, counts unanswered cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == ST_BUSY) && !mem_ready && !w_timeout) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Capture read data into MDR, and into IR for fetches, on completion only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir  <= '0;
            r_mdr <= '0;
        end else if (w_done && !r_we) begin
            r_mdr <= mem_rdata;
            if (r_ir_load) r_ir <= mem_rdata;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_align_err   <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept && (w_sel_addr[1:0] != 2'b00)) r_align_err <= 1'b1;
            if (w_accept && MemRead && MemWrite)        r_cmd_err   <= 1'b1;
            if (w_timeout)                              r_timeout_err <= 1'b1;
        end
    end

    assign mem_req     = (r_state == ST_BUSY);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign Instruction = r_ir;
    assign MDR         = r_mdr;
    assign OpCode      = r_ir[31:26];
    assign Rs          = r_ir[25:21];
    assign Rt          = r_ir[20:16];
    assign Rd          = r_ir[15:11];
    assign Shamt       = r_ir[10:6];
    assign Funct       = r_ir[5:0];
    assign Imm16       = r_ir[15:0];
    assign JumpAddr    = r_ir[25:0];
    assign AlignErr    = r_align_err;
    assign CmdErr      = r_cmd_err;
    assign TimeoutErr  = r_timeout_err;

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: the driver pushes the expected memory
// request for each command, a monitor compares it on every BUSY cycle and
// retires it on completion; directed checks cover IR/MDR, stalls and flags.
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, IorD, IRWrite;
    logic [31:0] PC, ALUOut, WriteData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        Stall;
    logic [31:0] Instruction, MDR;
    logic [5:0]  OpCode, Funct;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [15:0] Imm16;
    logic [25:0] JumpAddr;
    logic        AlignErr, CmdErr, TimeoutErr;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Memory responder configuration.
    int          cfg_waits = 0;
    logic [31:0] cfg_rdata = '0;
    int          busy_cyc  = 0;

    mem_interface #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .Stall(Stall),
        .Instruction(Instruction), .OpCode(OpCode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .Shamt(Shamt), .Funct(Funct), .Imm16(Imm16), .JumpAddr(JumpAddr), .MDR(MDR),
        .AlignErr(AlignErr), .CmdErr(CmdErr), .TimeoutErr(TimeoutErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: answers after cfg_waits BUSY cycles (255 = never).
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (busy_cyc == cfg_waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = cfg_rdata;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hXXXX_XXXX;
                end
                busy_cyc++;
            end else begin
                mem_ready = 1'b0;
                busy_cyc  = 0;
            end
        end
    end

    // Monitor: request fields must match the expected entry on every BUSY cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && mem_ready && sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_completion: addr %h with no expected request", mem_addr);
            end else if (mem_req && sb.size() > 0) begin
                chk("req_addr",  mem_addr,  sb[0].addr);
                chk("req_we",    {31'd0, mem_we}, {31'd0, sb[0].we});
                chk("req_wdata", mem_wdata, sb[0].wdata);
                if (mem_ready) void'(sb.pop_front());
            end
        end
    end

    // Issue one command and hold it until Stall drops; returns stall cycles.
    task automatic do_cmd(input logic rd, input logic wr, input logic iord, input logic irw,
                          input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] rdata, input int waits, output int stalls);
        exp_t e;
        logic [31:0] a;
        @(posedge clk);
        #2;
        a       = iord ? alu : pc;
        e.addr  = {a[31:2], 2'b00};
        e.we    = wr;
        e.wdata = wd;
        sb.push_back(e);
        cfg_waits = waits;
        cfg_rdata = rdata;
        MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
        PC = pc; ALUOut = alu; WriteData = wd;
        stalls = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (Stall) stalls++;
            else break;
        end
        if (stalls >= 40) begin
            n_checks++;
            n_err++;
            $display("FAIL stall_bound: Stall still high after %0d cycles", stalls);
        end
        @(posedge clk);
        #2;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    endtask

    initial begin
        int st;
        reset = 1'b1;
        MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
        PC = '0; ALUOut = '0; WriteData = '0;
        #23;
        chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we},  32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_ir",   Instruction, 32'd0);
        chk("rst_mdr",  MDR, 32'd0);
        chk("rst_flags", {29'd0, AlignErr, CmdErr, TimeoutErr}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        reset = 1'b0;

        // Fetch, zero wait.
        do_cmd(1, 0, 0, 1, 32'h0040_0004, 32'h1001_0000, 32'h0, 32'h8D09_0004, 0, st);
        chk("fetch_stalls", st, 1);
        chk("fetch_ir",  Instruction, 32'h8D09_0004);
        chk("fetch_mdr", MDR, 32'h8D09_0004);
        chk("fetch_op",  {26'd0, OpCode}, 32'h23);
        chk("fetch_rs",  {27'd0, Rs}, 32'd8);
        chk("fetch_rt",  {27'd0, Rt}, 32'd9);
        chk("fetch_imm", {16'd0, Imm16}, 32'h0004);
        chk("fetch_jaddr", {6'd0, JumpAddr}, 32'h0109_0004);

        // Load, three wait states, IR untouched.
        do_cmd(1, 0, 1, 0, 32'h0040_0008, 32'h1001_0008, 32'h0, 32'h1234_5678, 3, st);
        chk("load_stalls", st, 4);
        chk("load_mdr", MDR, 32'h1234_5678);
        chk("load_ir",  Instruction, 32'h8D09_0004);

        // Store with IRWrite also high: nothing local changes.
        do_cmd(0, 1, 1, 1, 32'h0040_000C, 32'h1001_000C, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2, st);
        chk("store_stalls", st, 3);
        chk("store_mdr", MDR, 32'h1234_5678);
        chk("store_ir",  Instruction, 32'h8D09_0004);
        chk("store_flags", {29'd0, AlignErr, CmdErr, TimeoutErr}, 32'd0);

        // Misaligned load.
        do_cmd(1, 0, 1, 0, 32'h0040_0010, 32'h1001_0006, 32'h0, 32'h0BAD_F00D, 0, st);
        chk("align_mdr", MDR, 32'h0BAD_F00D);
        chk("align_flags", {29'd0, AlignErr, CmdErr, TimeoutErr}, 32'b100);

        // Read and write together: performed as a write.
        do_cmd(1, 1, 0, 1, 32'h0040_0010, 32'h0, 32'h1122_3344, 32'h5555_AAAA, 1, st);
        chk("cmd_stalls", st, 2);
        chk("cmd_mdr", MDR, 32'h0BAD_F00D);
        chk("cmd_ir",  Instruction, 32'h8D09_0004);
        chk("cmd_flags", {29'd0, AlignErr, CmdErr, TimeoutErr}, 32'b110);

        // Never answered: abort after 16 BUSY cycles.
        do_cmd(1, 0, 0, 1, 32'h0040_0020, 32'h0, 32'h0, 32'h7777_7777, 255, st);
        sb.delete();
        chk("to_stalls", st, 16);
        chk("to_flags", {29'd0, AlignErr, CmdErr, TimeoutErr}, 32'b111);
        chk("to_ir",  Instruction, 32'h8D09_0004);
        chk("to_mdr", MDR, 32'h0BAD_F00D);
        @(negedge clk);
        chk("to_req_dropped", {31'd0, mem_req}, 32'd0);

        // Reset during the second wait cycle of a fetch.
        @(posedge clk);
        #2;
        cfg_waits = 255;
        MemRead = 1; IRWrite = 1; IorD = 0; PC = 32'h0040_0024;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_before", {31'd0, mem_req}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_req",  {31'd0, mem_req}, 32'd0);
        chk("mid_ir",   Instruction, 32'd0);
        chk("mid_mdr",  MDR, 32'd0);
        chk("mid_flags", {29'd0, AlignErr, CmdErr, TimeoutErr}, 32'd0);
        MemRead = 0; IRWrite = 0;
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Normal fetch after reset release.
        do_cmd(1, 0, 0, 1, 32'h0040_0024, 32'h0, 32'h0, 32'h012A_4020, 1, st);
        chk("post_stalls", st, 2);
        chk("post_ir",  Instruction, 32'h012A_4020);
        chk("post_rd",  {27'd0, Rd}, 32'd8);
        chk("post_funct", {26'd0, Funct}, 32'h20);
        chk("post_flags", {29'd0, AlignErr, CmdErr, TimeoutErr}, 32'd0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_drain: %0d expected requests never completed", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
